// File: rtl/sd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_engine
// Description : SD-host CMD-line engine. Serialises a 48-bit command frame
//               {0,1,index,argument,CRC7,1} onto the CMD pin. It then
//               optionally waits, with a timeout, for a 48-bit or 136-bit
//               response, checks it, and reports results through a
//               two-acknowledge handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro: CMD_CRC_CHECK_EN
//   defined   : receive-path CRC7 is computed and compared in CHECK
//   undefined : crc_error reflects only the response end bit
// ----------------------------------------------------------------------------
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   new_command           start request (sampled only in IDLE)
//   cmd_index/argument    command fields, latched in LOAD
//   resp_type             00 none, 01 short, 10 long (136b), 11 short no CRC
//   timeout_enable        abort response wait after TIMEOUT_TICKS bit ticks
//   cmd_pin_in            sampled CMD line
//   cmd_pin_out, cmd_oe   CMD line drive value and output enable
//   busy                  high outside IDLE
//   response              received frame, right-aligned
//   response_ready, no_response, crc_error, command_complete  status flags
//   ack_response, ack_command_complete  clear the matching status flag
// ============================================================================
module sd_cmd_engine #(
  parameter int CLK_DIV       = 2,
  parameter int TIMEOUT_TICKS = 64,
  parameter int TO_W          = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         new_command,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_argument,
  input  logic [1:0]   resp_type,
  input  logic         timeout_enable,
  input  logic         cmd_pin_in,
  output logic         cmd_pin_out,
  output logic         cmd_oe,
  output logic         busy,
  output logic [135:0] response,
  output logic         response_ready,
  output logic         no_response,
  output logic         crc_error,
  output logic         command_complete,
  input  logic         ack_response,
  input  logic         ack_command_complete
);

  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_RESP = 3'd3,
    RECV      = 3'd4,
    CHECK     = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [47:0]      frame;
  logic [5:0]       tx_cnt;
  logic [7:0]       rx_cnt;
  logic [7:0]       rx_last;
  logic [TO_W-1:0]  to_cnt;
  logic [1:0]       rtype;
  logic             timeout_hit;
  logic [6:0]       tx_crc;

  // One CRC7 step, polynomial x^7 + x^3 + 1, MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  assign tx_crc      = crc7_40({2'b01, cmd_index, cmd_argument});
  assign tick        = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rx_last     = (rtype == 2'b10) ? 8'd135 : 8'd47;
  assign timeout_hit = timeout_enable && (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

`ifdef CMD_CRC_CHECK_EN
  logic [6:0] crc_rx;
  logic       crc_window;
  // rx_cnt is the index of the arriving bit (start bit = 0). Short frames
  // cover bits 0..39 (frame [47:8]); long frames cover 8..127 (frame [127:8]).
  // The start bit of a short frame is a 0 into a zero CRC, so skipping it
  // leaves the result unchanged.
  assign crc_window = (rtype == 2'b10) ? (rx_cnt >= 8'd8 && rx_cnt <= 8'd127)
                                       : (rx_cnt <= 8'd39);
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cmd_oe      = 1'b0;
    cmd_pin_out = 1'b1;
    busy        = (state != IDLE);
    case (state)
      IDLE:      if (new_command) state_next = LOAD;
      LOAD:      state_next = SEND;
      SEND: begin
        cmd_oe      = 1'b1;
        cmd_pin_out = frame[47];
        if (tick && tx_cnt == 6'd47)
          state_next = (rtype == 2'b00) ? DONE : WAIT_RESP;
      end
      WAIT_RESP: begin
        if (tick) begin
          if (!cmd_pin_in)      state_next = RECV;
          else if (timeout_hit) state_next = DONE;
        end
      end
      RECV:      if (tick && rx_cnt == rx_last) state_next = CHECK;
      CHECK:     state_next = DONE;
      DONE: begin
        // Leave once command_complete is (being) cleared and response_ready
        // is either already clear or being acknowledged this cycle.
        if ((ack_command_complete || !command_complete) &&
            (ack_response || !response_ready))
          state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt          <= '0;
      frame            <= '1;
      tx_cnt           <= '0;
      rx_cnt           <= '0;
      to_cnt           <= '0;
      rtype            <= 2'b00;
      response         <= '0;
      response_ready   <= 1'b0;
      no_response      <= 1'b0;
      crc_error        <= 1'b0;
      command_complete <= 1'b0;
`ifdef CMD_CRC_CHECK_EN
      crc_rx           <= '0;
`endif
    end else begin
      if (state == SEND || state == WAIT_RESP || state == RECV)
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;

      case (state)
        LOAD: begin
          frame       <= {2'b01, cmd_index, cmd_argument, tx_crc, 1'b1};
          tx_cnt      <= '0;
          rx_cnt      <= '0;
          to_cnt      <= '0;
          rtype       <= resp_type;
          response    <= '0;
          no_response <= 1'b0;
          crc_error   <= 1'b0;
`ifdef CMD_CRC_CHECK_EN
          crc_rx      <= '0;
`endif
        end
        SEND: begin
          if (tick) begin
            frame  <= {frame[46:0], 1'b1};
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        WAIT_RESP: begin
          if (tick) begin
            if (!cmd_pin_in) begin
              response <= {response[134:0], 1'b0};
              rx_cnt   <= 8'd1;
            end else if (timeout_enable) begin
              to_cnt <= to_cnt + 1'b1;
              if (timeout_hit) no_response <= 1'b1;
            end
          end
        end
        RECV: begin
          if (tick) begin
            response <= {response[134:0], cmd_pin_in};
            rx_cnt   <= rx_cnt + 1'b1;
`ifdef CMD_CRC_CHECK_EN
            if (crc_window) crc_rx <= crc7_step(crc_rx, cmd_pin_in);
`endif
          end
        end
        CHECK: begin
`ifdef CMD_CRC_CHECK_EN
          if (rtype == 2'b11) crc_error <= ~response[0];
          else                crc_error <= ~response[0] | (crc_rx != response[7:1]);
`else
          crc_error <= ~response[0];
`endif
        end
        default: ;
      endcase

      if (state == CHECK)    response_ready <= 1'b1;
      else if (ack_response) response_ready <= 1'b0;

      if (state != DONE && state_next == DONE) command_complete <= 1'b1;
      else if (ack_command_complete)           command_complete <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_cmd_engine
// Description : Directed self-checking bench for sd_cmd_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_engine;

  localparam int CLK_DIV = 2;
  localparam int TMO     = 64;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         new_command = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_argument = '0;
  logic [1:0]   resp_type = '0;
  logic         timeout_enable = 1'b0;
  logic         cmd_pin_in = 1'b1;
  logic         cmd_pin_out, cmd_oe, busy;
  logic [135:0] response;
  logic         response_ready, no_response, crc_error, command_complete;
  logic         ack_response = 1'b0;
  logic         ack_command_complete = 1'b0;

  int checks = 0;
  int fails  = 0;
  logic [47:0] tx_stream;
  int          oe_cycles;

  sd_cmd_engine #(.CLK_DIV(CLK_DIV), .TIMEOUT_TICKS(TMO), .TO_W(8)) dut (
    .clock(clock), .reset(reset), .new_command(new_command),
    .cmd_index(cmd_index), .cmd_argument(cmd_argument), .resp_type(resp_type),
    .timeout_enable(timeout_enable), .cmd_pin_in(cmd_pin_in),
    .cmd_pin_out(cmd_pin_out), .cmd_oe(cmd_oe), .busy(busy),
    .response(response), .response_ready(response_ready),
    .no_response(no_response), .crc_error(crc_error),
    .command_complete(command_complete), .ack_response(ack_response),
    .ack_command_complete(ack_command_complete)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] ref_crc7_120(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Start a command and capture the serial frame while cmd_oe is high.
  // Returns at the first negedge after cmd_oe drops.
  task automatic issue_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [1:0] rt, input logic to_en);
    int w;
    @(negedge clock);
    cmd_index = idx; cmd_argument = arg; resp_type = rt; timeout_enable = to_en;
    new_command = 1'b1;
    @(negedge clock);
    new_command = 1'b0;
    w = 0;
    while (!cmd_oe && w < 20) begin @(negedge clock); w++; end
    checks++;
    if (!cmd_oe) begin fails++; $display("FAIL oe_start: cmd_oe=%b required 1", cmd_oe); end
    tx_stream = '0; oe_cycles = 0;
    while (cmd_oe && oe_cycles < 400) begin
      if (oe_cycles % CLK_DIV == 0) tx_stream = {tx_stream[46:0], cmd_pin_out};
      oe_cycles++;
      @(negedge clock);
    end
  endtask

  task automatic drive_resp(input logic [135:0] bits, input int len);
    repeat (3 * CLK_DIV) @(negedge clock);
    for (int b = len - 1; b >= 0; b--) begin
      cmd_pin_in = bits[b];
      repeat (CLK_DIV) @(negedge clock);
    end
    cmd_pin_in = 1'b1;
  endtask

  task automatic wait_complete();
    int w;
    w = 0;
    while (!command_complete && w < 60) begin @(negedge clock); w++; end
    checks++;
    if (!command_complete) begin
      fails++; $display("FAIL wait_complete: command_complete=%b required 1", command_complete);
    end
  endtask

  task automatic ack_both();
    ack_response = 1'b1; ack_command_complete = 1'b1;
    @(negedge clock);
    ack_response = 1'b0; ack_command_complete = 1'b0;
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL ack_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (cmd_pin_out !== 1'b1) begin fails++; $display("FAIL rst_pin: got %b required 1", cmd_pin_out); end
    checks++; if (cmd_oe !== 1'b0) begin fails++; $display("FAIL rst_oe: got %b required 0", cmd_oe); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (response !== 136'd0) begin fails++; $display("FAIL rst_resp: got %h required 0", response); end
    checks++; if ({response_ready, no_response, crc_error, command_complete} !== 4'b0000) begin
      fails++; $display("FAIL rst_flags: got %b required 0000",
                        {response_ready, no_response, crc_error, command_complete});
    end
  endtask

  task automatic test_cmd0();
    issue_cmd(6'd0, 32'd0, 2'b00, 1'b0);
    checks++; if (oe_cycles != 96) begin fails++; $display("FAIL cmd0_oe_len: got %0d required 96", oe_cycles); end
    checks++; if (tx_stream !== 48'h400000000095) begin fails++; $display("FAIL cmd0_tx: got %h required 400000000095", tx_stream); end
    wait_complete();
    checks++; if (no_response !== 1'b0) begin fails++; $display("FAIL cmd0_nr: got %b required 0", no_response); end
    checks++; if (response_ready !== 1'b0) begin fails++; $display("FAIL cmd0_rr: got %b required 0", response_ready); end
    ack_both();
  endtask

  task automatic test_cmd8(input logic flip);
    logic [47:0] r;
    logic        exp_err;
    r = 48'h08000001AA13;
    if (flip) r[20] = ~r[20];
`ifdef CMD_CRC_CHECK_EN
    exp_err = flip;
`else
    exp_err = 1'b0;
`endif
    issue_cmd(6'd8, 32'h000001AA, 2'b01, 1'b1);
    checks++; if (tx_stream !== 48'h48000001AA87) begin fails++; $display("FAIL cmd8_tx: got %h required 48000001AA87", tx_stream); end
    drive_resp({88'd0, r}, 48);
    wait_complete();
    checks++; if (response !== {88'd0, r}) begin fails++; $display("FAIL cmd8_resp: got %h required %h", response, r); end
    checks++; if (crc_error !== exp_err) begin fails++; $display("FAIL cmd8_crc flip=%0b: got %b required %b", flip, crc_error, exp_err); end
    checks++; if (response_ready !== 1'b1) begin fails++; $display("FAIL cmd8_rr: got %b required 1", response_ready); end
    checks++; if (no_response !== 1'b0) begin fails++; $display("FAIL cmd8_nr: got %b required 0", no_response); end
    ack_both();
  endtask

  task automatic test_timeout();
    int n;
    issue_cmd(6'd8, 32'h000001AA, 2'b01, 1'b1);
    n = 0;
    while (!no_response && n < 400) begin @(negedge clock); n++; end
    checks++; if (n != TMO * CLK_DIV) begin fails++; $display("FAIL to_latency: got %0d cycles required %0d", n, TMO * CLK_DIV); end
    checks++; if (response !== 136'd0) begin fails++; $display("FAIL to_resp: got %h required 0", response); end
    checks++; if (command_complete !== 1'b1) begin fails++; $display("FAIL to_cc: got %b required 1", command_complete); end
    checks++; if (response_ready !== 1'b0) begin fails++; $display("FAIL to_rr: got %b required 0", response_ready); end
    ack_both();
  endtask

  task automatic test_no_timeout();
    issue_cmd(6'd8, 32'h000001AA, 2'b01, 1'b0);
    repeat (300) @(negedge clock);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL nto_busy: got %b required 1", busy); end
    checks++; if (no_response !== 1'b0) begin fails++; $display("FAIL nto_nr: got %b required 0", no_response); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL nto_rst_busy: got %b required 0", busy); end
  endtask

  task automatic test_long_resp();
    logic [119:0] data;
    logic [135:0] r2;
    data = 120'h0123456789ABCDEF0123456789ABCD;
    r2   = {8'h3F, data, ref_crc7_120(data), 1'b1};
    issue_cmd(6'd2, 32'd0, 2'b10, 1'b1);
    checks++; if (tx_stream[47:40] !== 8'h42) begin fails++; $display("FAIL cmd2_hdr: got %h required 42", tx_stream[47:40]); end
    drive_resp(r2, 136);
    wait_complete();
    checks++; if (response !== r2) begin fails++; $display("FAIL r2_resp: got %h required %h", response, r2); end
    checks++; if (crc_error !== 1'b0) begin fails++; $display("FAIL r2_crc: got %b required 0", crc_error); end
    ack_response = 1'b1;
    @(negedge clock);
    ack_response = 1'b0;
    checks++; if (response_ready !== 1'b0) begin fails++; $display("FAIL r2_rr_ack: got %b required 0", response_ready); end
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL r2_busy_hold: got %b required 1", busy); end
    checks++; if (command_complete !== 1'b1) begin fails++; $display("FAIL r2_cc_hold: got %b required 1", command_complete); end
    ack_command_complete = 1'b1;
    @(negedge clock);
    ack_command_complete = 1'b0;
    checks++; if (busy !== 1'b0 || command_complete !== 1'b0) begin
      fails++; $display("FAIL r2_final: busy=%b cc=%b required 0 0", busy, command_complete);
    end
  endtask

  task automatic test_reset_mid_send();
    int w;
    @(negedge clock);
    cmd_index = 6'd0; cmd_argument = 32'd0; resp_type = 2'b00; timeout_enable = 1'b0;
    new_command = 1'b1;
    @(negedge clock);
    new_command = 1'b0;
    w = 0;
    while (!cmd_oe && w < 20) begin @(negedge clock); w++; end
    repeat (20 * CLK_DIV) @(negedge clock);
    checks++; if (cmd_oe !== 1'b1) begin fails++; $display("FAIL mid_oe: got %b required 1", cmd_oe); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (cmd_oe !== 1'b0 || cmd_pin_out !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_rst: oe=%b pin=%b busy=%b required 0 1 0", cmd_oe, cmd_pin_out, busy);
    end
    reset = 1'b0;
    issue_cmd(6'd8, 32'h000001AA, 2'b00, 1'b0);
    checks++; if (tx_stream !== 48'h48000001AA87) begin fails++; $display("FAIL mid_retx: got %h required 48000001AA87", tx_stream); end
    checks++; if (oe_cycles != 96) begin fails++; $display("FAIL mid_retx_len: got %0d required 96", oe_cycles); end
    wait_complete();
    ack_both();
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8(1'b0);
    test_cmd8(1'b1);
    test_timeout();
    test_no_timeout();
    test_long_resp();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
